// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA memory-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> ACCESS -> DONE -> IDLE)
//   req_id_t    : requester identity, also the bit index into the req vector
//   MEM_LAT_MAX : largest legal access latency (fits the 4-bit cycle counter)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  localparam int unsigned MEM_LAT_MAX = 15;
  localparam int          CNT_W       = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the memory array.
//   cpu_* / dma_* : request side (req/we/addr/wdata in, rdata/ready out)
//   mem_*         : memory side (en/we/addr/wdata out, rdata in)
//   busy, gnt_dma : arbiter status
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters + memory)
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ready;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          gnt_dma;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, gnt_dma
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, gnt_dma
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req[1:0]  : request vector, bit index = req_id_t (0 = CPU, 1 = DMA)
//   last      : requester granted most recently
//   gnt_valid : at least one request present
//   gnt_id    : winner; the sole requester, or on a tie the one that is not 'last'
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic       gnt_valid,
  output req_id_t    gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_CPU;
    unique case (req)
      2'b01:   gnt_id = REQ_CPU;
      2'b10:   gnt_id = REQ_DMA;
      2'b11:   gnt_id = (last == REQ_CPU) ? REQ_DMA : REQ_CPU;
      default: gnt_id = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified instruction/data memory between the
// multicycle CPU and the DMA/loader port. Fixed-latency accesses, round-robin
// between the two requesters with the first tie after reset going to the CPU.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; aborts any access in flight
//   bus  : mem_port_arbiter_if.slave (cpu_*, dma_*, mem_*, busy, gnt_dma)
// Parameters:
//   AW, DW  : address / data width (must match the interface instance)
//   MEM_LAT : cycles mem_en is held per access, 1..15
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  // Counter value of the final ACCESS cycle; out-of-range latencies are
  // clamped into the legal 1..MEM_LAT_MAX window.
  localparam int unsigned LAT_EFF =
    (MEM_LAT < 1) ? 1 : ((MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAT_EFF - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  req_id_t          winner;
  req_id_t          last_grant;
  logic             we_q;

  logic             pick_valid;
  req_id_t          pick_id;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  rr_pick2 u_pick (
    .req       ({bus.dma_req, bus.cpu_req}),
    .last      (last_grant),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    if (pick_id == REQ_DMA) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end
  end

  // The registered mem_we/mem_addr/mem_wdata outputs double as the latched
  // request copy, so requester inputs are ignored once the grant is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      winner        <= REQ_CPU;
      last_grant    <= REQ_DMA;
      we_q          <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_ready <= 1'b0;
      bus.dma_rdata <= '0;
      bus.busy      <= 1'b0;
      bus.gnt_dma   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            winner        <= pick_id;
            we_q          <= sel_we;
            cnt           <= '0;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.busy      <= 1'b1;
            bus.gnt_dma   <= (pick_id == REQ_DMA);
            state         <= ACCESS;
          end
        end

        ACCESS: begin
          if (cnt == LAST_CNT) begin
            // mem_rdata is valid only in this final ACCESS cycle.
            last_grant    <= winner;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            if (winner == REQ_CPU) begin
              bus.cpu_ready <= 1'b1;
              bus.cpu_rdata <= we_q ? '0 : bus.mem_rdata;
            end else begin
              bus.dma_ready <= 1'b1;
              bus.dma_rdata <= we_q ? '0 : bus.mem_rdata;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          // No arbitration here: a request still high now is picked up in IDLE.
          bus.cpu_ready <= 1'b0;
          bus.cpu_rdata <= '0;
          bus.dma_ready <= 1'b0;
          bus.dma_rdata <= '0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Requester-side stimulus, [instance][0=cpu,1=dma]
  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  // Observed outputs
  logic        rdy   [2][2];
  logic [31:0] rdat  [2][2];
  logic        men [2], mwe [2], bsy [2], gdma [2];
  logic [31:0] maddr [2], mwdata [2], mrdata [2];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus_a ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus_b ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT_A)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT_B)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  assign bus_a.cpu_req = req[0][0];   assign bus_a.dma_req = req[0][1];
  assign bus_a.cpu_we = we[0][0];     assign bus_a.dma_we = we[0][1];
  assign bus_a.cpu_addr = addr[0][0]; assign bus_a.dma_addr = addr[0][1];
  assign bus_a.cpu_wdata = wdata[0][0]; assign bus_a.dma_wdata = wdata[0][1];
  assign bus_a.mem_rdata = mrdata[0];
  assign rdy[0][0] = bus_a.cpu_ready; assign rdy[0][1] = bus_a.dma_ready;
  assign rdat[0][0] = bus_a.cpu_rdata; assign rdat[0][1] = bus_a.dma_rdata;
  assign men[0] = bus_a.mem_en;       assign mwe[0] = bus_a.mem_we;
  assign maddr[0] = bus_a.mem_addr;   assign mwdata[0] = bus_a.mem_wdata;
  assign bsy[0] = bus_a.busy;         assign gdma[0] = bus_a.gnt_dma;

  assign bus_b.cpu_req = req[1][0];   assign bus_b.dma_req = req[1][1];
  assign bus_b.cpu_we = we[1][0];     assign bus_b.dma_we = we[1][1];
  assign bus_b.cpu_addr = addr[1][0]; assign bus_b.dma_addr = addr[1][1];
  assign bus_b.cpu_wdata = wdata[1][0]; assign bus_b.dma_wdata = wdata[1][1];
  assign bus_b.mem_rdata = mrdata[1];
  assign rdy[1][0] = bus_b.cpu_ready; assign rdy[1][1] = bus_b.dma_ready;
  assign rdat[1][0] = bus_b.cpu_rdata; assign rdat[1][1] = bus_b.dma_rdata;
  assign men[1] = bus_b.mem_en;       assign mwe[1] = bus_b.mem_we;
  assign maddr[1] = bus_b.mem_addr;   assign mwdata[1] = bus_b.mem_wdata;
  assign bsy[1] = bus_b.busy;         assign gdma[1] = bus_b.gnt_dma;

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  // Memory array model: data is valid only in the last enabled cycle,
  // writes land on that cycle's edge; other cycles return junk.
  logic [31:0] dmem [2][256];
  int unsigned encnt [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (men[i]) begin
        if (encnt[i] == unsigned'(lat_of(i) - 1) && mwe[i])
          dmem[i][maddr[i][9:2]] <= mwdata[i];
        encnt[i] <= encnt[i] + 1;
      end else begin
        encnt[i] <= 0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mrdata[i] = 32'hBAD0_0000 | encnt[i];
      if (men[i] && !mwe[i] && encnt[i] == unsigned'(lat_of(i) - 1))
        mrdata[i] = dmem[i][maddr[i][9:2]];
    end
  end

  // Transaction-level reference: a grant occupies the port for LAT+2 edges,
  // completion is visible LAT edges after the grant edge.
  longint      k;
  longint      nge [2];
  longint      g   [2];
  int          win [2];
  int          lastg [2];
  bit          anyg [2];
  logic        ewe [2];
  logic [31:0] eaddr [2], ewd [2], erd [2];
  logic [31:0] refm [2][256];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int i);
    int w;
    if (rst) begin
      nge[i]   = k + 1;
      lastg[i] = 1;
      anyg[i]  = 0;
      g[i]     = -1000;
    end else if (k >= nge[i] && (req[i][0] || req[i][1])) begin
      if (req[i][0] && req[i][1]) w = (lastg[i] == 0) ? 1 : 0;
      else                        w = req[i][1] ? 1 : 0;
      win[i]   = w;
      lastg[i] = w;
      anyg[i]  = 1;
      g[i]     = k;
      nge[i]   = k + lat_of(i) + 2;
      ewe[i]   = we[i][w];
      eaddr[i] = addr[i][w];
      ewd[i]   = wdata[i][w];
      erd[i]   = ewe[i] ? 32'h0 : refm[i][eaddr[i][9:2]];
      if (ewe[i]) refm[i][eaddr[i][9:2]] = ewd[i];
    end
  endtask

  task automatic model_check(input int i);
    longint d;
    bit en, fin, busy_e;
    d      = k - g[i];
    en     = (d >= 0) && (d <= lat_of(i) - 1);
    fin    = (d == lat_of(i));
    busy_e = (d >= 0) && (d <= lat_of(i));
    chk($sformatf("i%0d c%0d busy", i, k), 32'(bsy[i]), 32'(busy_e));
    chk($sformatf("i%0d c%0d mem_en", i, k), 32'(men[i]), 32'(en));
    chk($sformatf("i%0d c%0d mem_we", i, k), 32'(mwe[i]), en ? 32'(ewe[i]) : 32'h0);
    chk($sformatf("i%0d c%0d mem_addr", i, k), maddr[i], en ? eaddr[i] : 32'h0);
    chk($sformatf("i%0d c%0d mem_wdata", i, k), mwdata[i], en ? ewd[i] : 32'h0);
    chk($sformatf("i%0d c%0d gnt_dma", i, k), 32'(gdma[i]), (anyg[i] && lastg[i] == 1) ? 32'h1 : 32'h0);
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("i%0d c%0d ready%0d", i, k, r), 32'(rdy[i][r]), (fin && win[i] == r) ? 32'h1 : 32'h0);
      chk($sformatf("i%0d c%0d rdata%0d", i, k, r), rdat[i][r], (fin && win[i] == r) ? erd[i] : 32'h0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    model_update(0);
    model_update(1);
    #1;
    model_check(0);
    model_check(1);
  endtask

  task automatic wait_rdy(input int i, input int r, input int maxc, output longint at);
    at = -1;
    for (int c = 0; c < maxc; c++) begin
      step();
      if (rdy[i][r] === 1'b1) begin
        at = k;
        break;
      end
    end
    total++;
    assert (at >= 0)
    else begin
      bad++;
      $error("FAIL wait_rdy i%0d r%0d observed=timeout expected=ready within %0d", i, r, maxc);
    end
  endtask

  initial begin
    longint ta, tb, k0;
    int order [$];
    longint tq [$];

    k = 0;
    for (int i = 0; i < 2; i++) begin
      nge[i] = 0; g[i] = -1000; win[i] = 0; lastg[i] = 1; anyg[i] = 0;
      ewe[i] = 0; eaddr[i] = 0; ewd[i] = 0; erd[i] = 0;
      for (int j = 0; j < 256; j++) begin
        dmem[i][j] = 32'hA500_0000 + 32'(j * 32'h0001_0203) + 32'(i);
        refm[i][j] = 32'hA500_0000 + 32'(j * 32'h0001_0203) + 32'(i);
      end
      for (int r = 0; r < 2; r++) begin
        req[i][r] = 0; we[i][r] = 0; addr[i][r] = 0; wdata[i][r] = 0;
      end
    end
    dmem[0][16] = 32'h1234ABCD;
    refm[0][16] = 32'h1234ABCD;

    rst = 1;
    step();
    step();
    rst = 0;

    // 1: CPU load only
    req[0][0] = 1; we[0][0] = 0; addr[0][0] = 32'h40;
    k0 = k;
    wait_rdy(0, 0, 10, ta);
    chk("t1_rdata", rdat[0][0], 32'h1234ABCD);
    chk("t1_latency", 32'(ta - k0), 32'(1 + LAT_A));
    req[0][0] = 0;
    step(); step();

    // 2: tie right after reset
    rst = 1;
    step();
    rst = 0;
    req[0][0] = 1; addr[0][0] = 32'h44;
    req[0][1] = 1; we[0][1] = 0; addr[0][1] = 32'h48;
    wait_rdy(0, 0, 8, ta);
    req[0][0] = 0;
    wait_rdy(0, 1, 8, tb);
    chk("t2_gap", 32'(tb - ta), 32'd4);
    chk("t2_gnt_dma", 32'(gdma[0]), 32'h1);
    req[0][1] = 0;
    step(); step();

    // 3: both held for four accesses
    req[0][0] = 1; addr[0][0] = 32'h50;
    req[0][1] = 1; addr[0][1] = 32'h54;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      step();
      if (rdy[0][0] === 1'b1) order.push_back(0);
      if (rdy[0][1] === 1'b1) order.push_back(1);
    end
    req[0][0] = 0; req[0][1] = 0;
    chk("t3_count", 32'(order.size()), 32'd4);
    for (int n = 0; n < order.size(); n++)
      chk($sformatf("t3_order%0d", n), 32'(order[n]), 32'(n % 2));
    step(); step();

    // 4: DMA store with address/data changed mid-access
    req[0][1] = 1; we[0][1] = 1; addr[0][1] = 32'h100; wdata[0][1] = 32'hDEADBEEF;
    step();
    addr[0][1] = 32'h200; wdata[0][1] = 32'h0BADF00D;
    wait_rdy(0, 1, 8, tb);
    chk("t4_dma_rdata", rdat[0][1], 32'h0);
    req[0][1] = 0; we[0][1] = 0;
    step(); step();
    req[0][0] = 1; we[0][0] = 0; addr[0][0] = 32'h100;
    wait_rdy(0, 0, 8, ta);
    chk("t4_readback", rdat[0][0], 32'hDEADBEEF);
    req[0][0] = 0;
    step(); step();

    // 5: reset in the second ACCESS cycle of a CPU load
    req[0][0] = 1; addr[0][0] = 32'h40;
    step();
    chk("t5_granted", 32'(men[0]), 32'h1);
    step();
    rst = 1;
    step();
    rst = 0;
    req[0][0] = 0;
    chk("t5_abort_en", 32'(men[0]), 32'h0);
    chk("t5_abort_rdy", 32'(rdy[0][0]), 32'h0);
    step();
    req[0][0] = 1; req[0][1] = 1; we[0][1] = 0; addr[0][1] = 32'h60;
    wait_rdy(0, 0, 4, ta);
    req[0][0] = 0;
    wait_rdy(0, 1, 8, tb);
    req[0][1] = 0;
    step(); step();

    // 6: MEM_LAT=1, back-to-back CPU loads
    req[1][0] = 1; we[1][0] = 0; addr[1][0] = 32'h10;
    for (int c = 0; c < 40 && tq.size() < 6; c++) begin
      step();
      if (rdy[1][0] === 1'b1) begin
        tq.push_back(k);
        addr[1][0] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
    end
    req[1][0] = 0;
    chk("t6_count", 32'(tq.size()), 32'd6);
    for (int n = 1; n < tq.size(); n++)
      chk($sformatf("t6_gap%0d", n), 32'(tq[n] - tq[n-1]), 32'd3);
    step(); step();

    // Random traffic on both instances
    for (int c = 0; c < 800; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 2; r++) begin
          if (req[i][r]) begin
            if (rdy[i][r] === 1'b1) begin
              req[i][r] = 0;
            end else if (win[i] == r && k >= g[i] && k - g[i] < lat_of(i)
                         && $urandom_range(0, 2) == 0) begin
              addr[i][r]  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
              wdata[i][r] = $urandom;
              we[i][r]    = 1'($urandom_range(0, 1));
            end
          end else if ($urandom_range(0, 2) == 0) begin
            req[i][r]   = 1;
            we[i][r]    = 1'($urandom_range(0, 1));
            addr[i][r]  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            wdata[i][r] = $urandom;
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
